convert_from_10: RTL
====================

Name: convert_from_10

Overview:
- Decimal-to-binary converter; the receiving counterpart of convert_to_10.
- Consumes a most-significant-first stream of 4-bit BCD digits (decimal/valid, terminated by last) and accumulates the binary integer with acc = acc*10 + digit, one digit per clock.
- Used for round-trip checks of the e-calculation output path and for loading decimal constants into wide binary registers.

Parameters:
- WIDTH, 400: width of the binary result in bits.
- CNT_W, 8: width of the digit counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; clears the accumulator and begins a conversion.
- decimal  input  4  BCD digit, valid 0..9.
- valid  input  1  decimal is presented this cycle.
- last  input  1  end of stream; may coincide with valid or arrive alone.
- binary  output  WIDTH  accumulated result; stable while done=1 and held until the next start.
- digit_count  output  CNT_W  number of digits accepted.
- busy  output  1  high from the cycle after start until the end of the stream.
- done  output  1  one-cycle pulse, the cycle after last is sampled.
- overflow  output  1  sticky; the true value has exceeded 2^WIDTH-1.
- bad_digit  output  1  sticky; a digit above 9 was presented.

Behaviour:
- Reset values (also when rst is asserted mid-conversion): state=IDLE; binary=0, digit_count=0, busy=0, done=0, overflow=0, bad_digit=0. The cycle after rst is released, the block is idle.
- FSM states are IDLE and RUN. done is a registered pulse, not a separate state.
- IDLE:
  - valid and last are ignored.
  - start -> binary=0, count=0, overflow=0, bad_digit=0, busy=1, go to RUN.
  - A digit presented in the same cycle as start is ignored; the first digit is accepted the cycle after start.
- RUN, valid=1, decimal<=9:
  - binary <= (binary*10 + decimal) mod 2^WIDTH.
  - The product is computed at WIDTH+4 bits; any nonzero bit above WIDTH-1 sets overflow. Accumulation continues after overflow.
  - digit_count increments and saturates at 2^CNT_W-1.
- RUN, valid=1, decimal>9:
  - binary and count unchanged; bad_digit is set.
- RUN, last=1:
  - A valid digit in the same cycle is processed first.
  - Then go to IDLE; busy=0 and done=1 on the next cycle, with the final binary already visible.
  - done lasts exactly 1 cycle.
- RUN, start=1: restart. Same actions as start in IDLE, and any valid digit in that cycle is dropped. Takes priority over last.
- Latency: one cycle per digit; done appears 1 cycle after last.
- Cost: *10 is implemented as (acc<<3)+(acc<<1). No multiplier is inferred.
- No back-pressure: one digit per cycle must always be accepted, matching the convert_to_10 output rate.

Decomposition:
- Shared package (conv_pkg):
  - DIGIT_W=4, DEC_MAX=4'd9.
  - State enum {IDLE, RUN}.
  - WIDTH default 400, also used by e_calc and convert_to_10.
- Sub-module mul10_add:
  - Combinational; inputs acc[WIDTH-1:0] and d[3:0].
  - Outputs sum[WIDTH-1:0] and carry[3:0], where carry!=0 means overflow.
  - Unit-testable on its own.

Test Plan:
- Basic conversion: start, then digits 1,2,3 on consecutive cycles with last on the 3 -> binary=123, digit_count=3, done high for exactly 1 cycle, busy low afterwards, flags 0.
- Separate last with a gap: start, digits 0,0,7, an idle cycle with valid=0, then last alone -> binary=7, count=3, done 1 cycle after last.
- Overflow (WIDTH=8 instance): digits 2,5,6 then last -> binary=0 (256 mod 256), overflow=1. Then start with digits 2,5,5 -> binary=255, overflow=0.
- Bad digit: digits 4, 0xC, 2, last -> binary=42, count=2, bad_digit=1.
- Reset and restart:
  - rst mid-stream after digits 9,9 -> all outputs 0 immediately. New start with digits 5, last -> binary=5.
  - start asserted mid-stream -> accumulator clears and the digit in that cycle is dropped.
- Full width: 120 digits of "1" -> binary equals a software model of (10^120-1)/9, overflow=0, count=120. Loopback convert_to_10 -> convert_from_10 on a fixed 400-bit integer -> identical value.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the decimal/binary conversion blocks.
// WIDTH_DEF is the common result width used by e_calc and convert_to_10 as well.
package conv_pkg;

  localparam int          DIGIT_W   = 4;
  localparam logic [3:0]  DEC_MAX   = 4'd9;
  localparam int          WIDTH_DEF = 400;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/mul10_add.sv
// Combinational acc*10 + d using shift-and-add so no multiplier is inferred.
// carry holds the bits above WIDTH-1; any nonzero carry means the result wrapped.
module mul10_add #(
  parameter int WIDTH = 400
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       d,
  output logic [WIDTH-1:0] sum,
  output logic [3:0]       carry
);

  logic [WIDTH+3:0] accWide;
  logic [WIDTH+3:0] total;

  // acc*10 needs at most 4 extra bits, and adding a digit below 16 cannot exceed that.
  assign accWide = {4'b0000, acc};
  assign total   = (accWide << 3) + (accWide << 1) + {{WIDTH{1'b0}}, d};
  assign sum     = total[WIDTH-1:0];
  assign carry   = total[WIDTH+3:WIDTH];

endmodule

// File: rtl/convert_from_10.sv
// Decimal-to-binary converter: accumulates a most-significant-first BCD digit stream
// into a WIDTH-bit integer, one digit per clock, with sticky overflow and bad-digit flags.
module convert_from_10
  import conv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       decimal,
  input  logic             valid,
  input  logic             last,
  output logic [WIDTH-1:0] binary,
  output logic [CNT_W-1:0] digit_count,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             bad_digit
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             bad_q, bad_d;

  logic [WIDTH-1:0] nextAcc;
  logic [3:0]       carry;

  mul10_add #(.WIDTH(WIDTH)) u_mul10_add (
    .acc   (acc_q),
    .d     (decimal),
    .sum   (nextAcc),
    .carry (carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    bad_d   = bad_q;

    // start wins over everything, so a digit or last arriving with it is dropped.
    if (start) begin
      state_d = RUN;
      acc_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
      ovf_d   = 1'b0;
      bad_d   = 1'b0;
    end else if (state_q == RUN) begin
      if (valid) begin
        if (decimal > DEC_MAX) begin
          bad_d = 1'b1;
        end else begin
          acc_d = nextAcc;
          if (carry != 4'd0) ovf_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      if (last) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

  assign binary      = acc_q;
  assign digit_count = cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign bad_digit   = bad_q;

endmodule
